// File: rtl/bram_sdp_pipelined.sv
// Simple-dual-port block RAM with byte-enable writes, a 1- or 2-cycle read pipeline and an optional zero-fill after reset.
// Define BRAM_FWD_EN for write-first same-address read-during-write. Without it, the read returns the pre-write word (read-first).
module bram_sdp_pipelined #(
    parameter int unsigned BRAM_WIDTH     = 32,
    parameter int unsigned BRAM_DEPTH     = 256,
    parameter int unsigned OUT_REG        = 0,
    parameter int unsigned CLEAR_ON_RESET = 1,
    localparam int unsigned AW = (BRAM_DEPTH > 1) ? $clog2(BRAM_DEPTH) : 1,
    localparam int unsigned NB = BRAM_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [NB-1:0]         wbe,
    input  logic [AW-1:0]         addrin,
    input  logic [BRAM_WIDTH-1:0] din,
    input  logic                  re,
    input  logic [AW-1:0]         addrout,
    output logic [BRAM_WIDTH-1:0] dout,
    output logic                  dout_vld,
    output logic                  init_done
);

    typedef enum logic [1:0] {RST_WAIT, CLEAR, RUN} state_t;

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(BRAM_DEPTH);
    localparam logic [AW-1:0] LAST_C  = AW'(BRAM_DEPTH - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [AW-1:0]           r_clr_cnt;
    logic                    r_init_done;
    logic [BRAM_WIDTH-1:0]   r_mem [BRAM_DEPTH];

    logic                    w_run;
    logic                    w_wr_ok;
    logic                    w_rd_ok;
    logic                    w_rd_in;
    logic [BRAM_WIDTH-1:0]   w_rd_data;

    logic                    r_vld1;
    logic [BRAM_WIDTH-1:0]   r_d1;

    assign w_run     = (r_state == RUN);
    assign w_wr_ok   = w_run && we && ({1'b0, addrin} < DEPTH_C);
    assign w_rd_ok   = w_run && re;
    assign w_rd_in   = ({1'b0, addrout} < DEPTH_C);
    assign init_done = r_init_done;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RST_WAIT: w_state_nxt = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            CLEAR:    if (r_clr_cnt == LAST_C) w_state_nxt = RUN;
            RUN:      w_state_nxt = RUN;
            default:  w_state_nxt = RST_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RST_WAIT;
            r_clr_cnt   <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_done <= (w_state_nxt == RUN);
            if (r_state == CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
            else                  r_clr_cnt <= '0;
        end
    end

    // Storage array has no reset so it maps onto block RAM; the FSM gates every update.
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_ok) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wbe[i]) r_mem[addrin][8*i +: 8] <= din[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        if (w_rd_in) begin
            w_rd_data = r_mem[addrout];
`ifdef BRAM_FWD_EN
            if (w_wr_ok && (addrin == addrout)) begin
                for (int unsigned i = 0; i < NB; i++) begin
                    if (wbe[i]) w_rd_data[8*i +: 8] = din[8*i +: 8];
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld1 <= 1'b0;
            r_d1   <= '0;
        end else begin
            r_vld1 <= w_rd_ok;
            if (w_rd_ok) r_d1 <= w_rd_data;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  r_vld2;
            logic [BRAM_WIDTH-1:0] r_d2;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld2 <= 1'b0;
                    r_d2   <= '0;
                end else begin
                    r_vld2 <= r_vld1;
                    if (r_vld1) r_d2 <= r_d1;
                end
            end

            assign dout     = r_d2;
            assign dout_vld = r_vld2;
        end else begin : g_no_out_reg
            assign dout     = r_d1;
            assign dout_vld = r_vld1;
        end
    endgenerate

endmodule

// File: tb/tb_bram_sdp_pipelined.sv
// Directed bench for bram_sdp_pipelined: three instances (latency 1, latency 2, depth 200 without clear) share one stimulus set.
module tb_bram_sdp_pipelined;

    logic        clk;
    logic        rst;
    logic        we;
    logic [3:0]  wbe;
    logic [7:0]  addrin;
    logic [31:0] din;
    logic        re;
    logic [7:0]  addrout;
    logic [31:0] d0, d1, d2;
    logic        v0, v1, v2;
    logic        i0, i1, i2;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef BRAM_FWD_EN
    localparam logic [31:0] RDW_EXP = 32'h11112222;
`else
    localparam logic [31:0] RDW_EXP = 32'h11111111;
`endif

    bram_sdp_pipelined #(.BRAM_WIDTH(32), .BRAM_DEPTH(256), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
        .clk(clk), .rst(rst), .we(we), .wbe(wbe), .addrin(addrin), .din(din), .re(re),
        .addrout(addrout), .dout(d0), .dout_vld(v0), .init_done(i0));
    bram_sdp_pipelined #(.BRAM_WIDTH(32), .BRAM_DEPTH(256), .OUT_REG(1), .CLEAR_ON_RESET(1)) u1 (
        .clk(clk), .rst(rst), .we(we), .wbe(wbe), .addrin(addrin), .din(din), .re(re),
        .addrout(addrout), .dout(d1), .dout_vld(v1), .init_done(i1));
    bram_sdp_pipelined #(.BRAM_WIDTH(32), .BRAM_DEPTH(200), .OUT_REG(0), .CLEAR_ON_RESET(0)) u2 (
        .clk(clk), .rst(rst), .we(we), .wbe(wbe), .addrin(addrin), .din(din), .re(re),
        .addrout(addrout), .dout(d2), .dout_vld(v2), .init_done(i2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int cnt;
        int stray;
        rst = 1'b1; we = 1'b0; re = 1'b0; wbe = '0; addrin = '0; addrout = '0; din = '0;
        repeat (3) step();
        n_cmp++; if ({i0, v0, d0} !== 34'h0) begin n_bad++; $display("FAIL rst_u0 got %h exp %h", {i0, v0, d0}, 34'h0); end
        n_cmp++; if ({i1, v1, d1} !== 34'h0) begin n_bad++; $display("FAIL rst_u1 got %h exp %h", {i1, v1, d1}, 34'h0); end
        n_cmp++; if ({i2, v2, d2} !== 34'h0) begin n_bad++; $display("FAIL rst_u2 got %h exp %h", {i2, v2, d2}, 34'h0); end
        rst = 1'b0;
        step();
        cnt = 1;
        stray = 0;
        n_cmp++; if ({i0, i2} !== 2'b01) begin n_bad++; $display("FAIL first_edge_init got %b exp %b", {i0, i2}, 2'b01); end
        while (i0 !== 1'b1 && cnt < 400) begin
            we = (cnt == 100); re = (cnt == 100); addrin = 8'd5; addrout = 8'd5; din = '1; wbe = '1;
            step();
            cnt++;
            if (v0 !== 1'b0 || v1 !== 1'b0) stray++;
        end
        we = 1'b0; re = 1'b0;
        n_cmp++; if (cnt !== 257) begin n_bad++; $display("FAIL clear_len got %0d exp %0d", cnt, 257); end
        n_cmp++; if (i1 !== 1'b1) begin n_bad++; $display("FAIL clear_u1_init got %b exp %b", i1, 1'b1); end
        n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL clear_stray_vld got %0d exp %0d", stray, 0); end
    endtask

    task automatic test_clear_reads();
        logic [7:0] a [4];
        a[0] = 8'd0; a[1] = 8'd5; a[2] = 8'd128; a[3] = 8'd255;
        for (int k = 0; k < 4; k++) begin
            addrout = a[k]; re = 1'b1;
            step();
            re = 1'b0;
            n_cmp++; if ({v0, d0, v1} !== {1'b1, 32'h0, 1'b0}) begin n_bad++; $display("FAIL clr_rd_l1 a=%0d got %h exp %h", a[k], {v0, d0, v1}, {1'b1, 32'h0, 1'b0}); end
            step();
            n_cmp++; if ({v1, d1, v0} !== {1'b1, 32'h0, 1'b0}) begin n_bad++; $display("FAIL clr_rd_l2 a=%0d got %h exp %h", a[k], {v1, d1, v0}, {1'b1, 32'h0, 1'b0}); end
        end
    endtask

    task automatic test_byte_write();
        we = 1'b1; addrin = 8'd5; din = 32'hDEADBEEF; wbe = 4'b1111;
        step();
        din = 32'h000000AA; wbe = 4'b0001;
        step();
        we = 1'b0; re = 1'b1; addrout = 8'd5;
        step();
        re = 1'b0;
        n_cmp++; if ({v0, d0, v1} !== {1'b1, 32'hDEADBEAA, 1'b0}) begin n_bad++; $display("FAIL bw_u0 got %h exp %h", {v0, d0, v1}, {1'b1, 32'hDEADBEAA, 1'b0}); end
        n_cmp++; if ({v2, d2} !== {1'b1, 32'hDEADBEAA}) begin n_bad++; $display("FAIL bw_u2 got %h exp %h", {v2, d2}, {1'b1, 32'hDEADBEAA}); end
        step();
        n_cmp++; if ({v1, d1} !== {1'b1, 32'hDEADBEAA}) begin n_bad++; $display("FAIL bw_u1 got %h exp %h", {v1, d1}, {1'b1, 32'hDEADBEAA}); end
        n_cmp++; if ({v0, d0} !== {1'b0, 32'hDEADBEAA}) begin n_bad++; $display("FAIL bw_u0_hold got %h exp %h", {v0, d0}, {1'b0, 32'hDEADBEAA}); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] dv [3];
        dv[0] = 32'h01020304; dv[1] = 32'h11223344; dv[2] = 32'h55667788;
        wbe = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            we = 1'b1; addrin = 8'(k + 1); din = dv[k];
            step();
        end
        we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            re = (k < 3); addrout = 8'(k + 1);
            step();
            if (k < 3) begin
                n_cmp++; if ({v0, d0} !== {1'b1, dv[k]}) begin n_bad++; $display("FAIL b2b_u0 k=%0d got %h exp %h", k, {v0, d0}, {1'b1, dv[k]}); end
                n_cmp++; if ({v2, d2} !== {1'b1, dv[k]}) begin n_bad++; $display("FAIL b2b_u2 k=%0d got %h exp %h", k, {v2, d2}, {1'b1, dv[k]}); end
            end else begin
                n_cmp++; if ({v0, d0} !== {1'b0, dv[2]}) begin n_bad++; $display("FAIL b2b_u0_end got %h exp %h", {v0, d0}, {1'b0, dv[2]}); end
            end
            if (k == 0) begin
                n_cmp++; if (v1 !== 1'b0) begin n_bad++; $display("FAIL b2b_u1_lat got %b exp %b", v1, 1'b0); end
            end else begin
                n_cmp++; if ({v1, d1} !== {1'b1, dv[k-1]}) begin n_bad++; $display("FAIL b2b_u1 k=%0d got %h exp %h", k, {v1, d1}, {1'b1, dv[k-1]}); end
            end
        end
        step();
        n_cmp++; if ({v1, d1} !== {1'b0, dv[2]}) begin n_bad++; $display("FAIL b2b_u1_end got %h exp %h", {v1, d1}, {1'b0, dv[2]}); end
    endtask

    task automatic test_rdw();
        we = 1'b1; addrin = 8'd7; din = 32'h11111111; wbe = 4'b1111;
        step();
        din = 32'h22222222; wbe = 4'b0011; re = 1'b1; addrout = 8'd7;
        step();
        we = 1'b0; re = 1'b0;
        n_cmp++; if ({v0, d0} !== {1'b1, RDW_EXP}) begin n_bad++; $display("FAIL rdw_u0 got %h exp %h", {v0, d0}, {1'b1, RDW_EXP}); end
        n_cmp++; if ({v2, d2} !== {1'b1, RDW_EXP}) begin n_bad++; $display("FAIL rdw_u2 got %h exp %h", {v2, d2}, {1'b1, RDW_EXP}); end
        step();
        n_cmp++; if ({v1, d1} !== {1'b1, RDW_EXP}) begin n_bad++; $display("FAIL rdw_u1 got %h exp %h", {v1, d1}, {1'b1, RDW_EXP}); end
        re = 1'b1;
        step();
        re = 1'b0;
        n_cmp++; if ({v0, d0} !== {1'b1, 32'h11112222}) begin n_bad++; $display("FAIL rdw_after_u0 got %h exp %h", {v0, d0}, {1'b1, 32'h11112222}); end
        n_cmp++; if ({v2, d2} !== {1'b1, 32'h11112222}) begin n_bad++; $display("FAIL rdw_after_u2 got %h exp %h", {v2, d2}, {1'b1, 32'h11112222}); end
        step();
        n_cmp++; if ({v1, d1} !== {1'b1, 32'h11112222}) begin n_bad++; $display("FAIL rdw_after_u1 got %h exp %h", {v1, d1}, {1'b1, 32'h11112222}); end
    endtask

    task automatic test_out_of_range();
        we = 1'b1; addrin = 8'd10; din = 32'hCAFEF00D; wbe = 4'b1111;
        step();
        addrin = 8'd210; din = 32'h12345678;
        step();
        we = 1'b0; re = 1'b1; addrout = 8'd210;
        step();
        n_cmp++; if ({v2, d2} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL oor_rd_u2 got %h exp %h", {v2, d2}, {1'b1, 32'h0}); end
        n_cmp++; if ({v0, d0} !== {1'b1, 32'h12345678}) begin n_bad++; $display("FAIL oor_rd_u0 got %h exp %h", {v0, d0}, {1'b1, 32'h12345678}); end
        addrout = 8'd10;
        step();
        re = 1'b0;
        n_cmp++; if ({v2, d2} !== {1'b1, 32'hCAFEF00D}) begin n_bad++; $display("FAIL oor_alias_u2 got %h exp %h", {v2, d2}, {1'b1, 32'hCAFEF00D}); end
    endtask

    task automatic test_mid_reset();
        int cnt;
        re = 1'b1; addrout = 8'd1;
        step();
        re = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++; if ({i0, v0, d0} !== 34'h0) begin n_bad++; $display("FAIL mrst_u0 got %h exp %h", {i0, v0, d0}, 34'h0); end
        n_cmp++; if ({i1, v1, d1} !== 34'h0) begin n_bad++; $display("FAIL mrst_u1 got %h exp %h", {i1, v1, d1}, 34'h0); end
        n_cmp++; if ({i2, v2, d2} !== 34'h0) begin n_bad++; $display("FAIL mrst_u2 got %h exp %h", {i2, v2, d2}, 34'h0); end
        step();
        n_cmp++; if (v1 !== 1'b0) begin n_bad++; $display("FAIL mrst_inflight_u1 got %b exp %b", v1, 1'b0); end
        rst = 1'b0;
        step();
        cnt = 1;
        while (cnt < 101) begin step(); cnt++; end
        rst = 1'b1;
        #1;
        n_cmp++; if ({i0, v0, i2} !== 3'b000) begin n_bad++; $display("FAIL mrst_clear_out got %b exp %b", {i0, v0, i2}, 3'b000); end
        step();
        rst = 1'b0;
        step();
        cnt = 1;
        while (i0 !== 1'b1 && cnt < 400) begin step(); cnt++; end
        n_cmp++; if (cnt !== 257) begin n_bad++; $display("FAIL mrst_clear_len got %0d exp %0d", cnt, 257); end
        re = 1'b1; addrout = 8'd1;
        step();
        n_cmp++; if ({v0, d0} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL mrst_rezero_u0 got %h exp %h", {v0, d0}, {1'b1, 32'h0}); end
        n_cmp++; if ({v2, d2} !== {1'b1, 32'h01020304}) begin n_bad++; $display("FAIL mrst_retain1_u2 got %h exp %h", {v2, d2}, {1'b1, 32'h01020304}); end
        addrout = 8'd10;
        step();
        re = 1'b0;
        n_cmp++; if ({v2, d2} !== {1'b1, 32'hCAFEF00D}) begin n_bad++; $display("FAIL mrst_retain10_u2 got %h exp %h", {v2, d2}, {1'b1, 32'hCAFEF00D}); end
        n_cmp++; if ({v1, d1} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL mrst_rezero_u1 got %h exp %h", {v1, d1}, {1'b1, 32'h0}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_clear_reads();
        test_byte_write();
        test_back_to_back();
        test_rdw();
        test_out_of_range();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
